// File: rtl/lcd_timing_pkg.sv
// Shared definitions for the DE-mode LCD scan path.
// Contents:
//   lcd_state_t   - lock state of the sink-side timing decoder
//   coord_t       - 16-bit pixel coordinate / cycle count
//   DEF_*         - default panel timing, common to generator and decoder
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } lcd_state_t;

  typedef logic [15:0] coord_t;

  localparam coord_t COORD_MAX = 16'hFFFF;

  localparam int DEF_H_ACTIVE    = 800;
  localparam int DEF_H_PERIOD    = 928;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_PERIOD    = 525;
  localparam int DEF_LOCK_FRAMES = 2;

endpackage

// File: rtl/sat_run_counter.sv
// 16-bit saturating event counter used for gap, run and period measurement.
// Ports:
//   clock   - pixel clock
//   reset_n - synchronous active-low reset, clears the count
//   clr     - restart measurement; the count restarts at en (0 or 1) so the
//             clearing cycle itself is counted when it is also an event
//   en      - count this cycle
//   cnt     - current count, sticks at 16'hFFFF
module sat_run_counter
  import lcd_timing_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] cnt
);

  function automatic coord_t sat_inc(input coord_t v);
    return (v == COORD_MAX) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= en ? 16'd1 : 16'd0;
    end else if (en) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/lcd_de_timing_decoder.sv
// Sink-side decoder for a DE-mode LCD scan stream. Recovers pixel
// coordinates, line/frame strobes and a lock flag from de alone, and flags
// geometry that disagrees with the configured timing.
// Ports:
//   clock, reset_n  - pixel clock, synchronous active-low reset
//   de              - data enable, one pixel per clock
//   pixel_valid     - registered de, suppressed while searching
//   pixel_x/pixel_y - coordinates of the pixel on pixel_valid
//   line_start      - pulse with pixel_x == 0
//   frame_start     - pulse with pixel_x == 0 and pixel_y == 0
//   locked          - decoder is locked to the stream
//   err_width       - active run length differed from H_ACTIVE
//   err_period      - rise-to-rise line distance differed from H_PERIOD
//   err_height      - finished frame line count differed from V_ACTIVE
// All outputs are registered: the sample taken on cycle n shows on n+1.
module lcd_de_timing_decoder
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_PERIOD    = DEF_H_PERIOD,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_PERIOD    = DEF_V_PERIOD,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        de,
  output logic        pixel_valid,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        err_width,
  output logic        err_period,
  output logic        err_height
);

  localparam coord_t     H_ACTIVE_C = 16'(H_ACTIVE);
  localparam coord_t     H_PERIOD_C = 16'(H_PERIOD);
  localparam coord_t     V_LAST_C   = 16'(V_ACTIVE - 1);
  localparam logic [3:0] LOCK_C     = 4'(LOCK_FRAMES);

  if (H_PERIOD <= H_ACTIVE || V_PERIOD <= V_ACTIVE) begin : g_bad_geometry
    $error("lcd_de_timing_decoder: blanking must be non-empty");
  end
  if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_lock
    $error("lcd_de_timing_decoder: LOCK_FRAMES must be 1..15");
  end

  function automatic coord_t sat_inc(input coord_t v);
    return (v == COORD_MAX) ? v : v + 16'd1;
  endfunction

  logic        de_d;
  logic        rise_p0, fall_p0, frame_rise_p0, line_rise_p0;
  logic [15:0] gap_cnt, run_cnt, per_cnt;
  lcd_state_t  state_q, state_nx;
  logic [3:0]  clean_q, clean_nx;
  logic        dirty_q, dirty_nx;
  logic        ew_p0, ep_p0, eh_p0, frame_clean_p0;
  logic        active_p0, valid_nx, ls_nx, fs_nx;
  logic [15:0] x_nx, y_nx;

  // ---- stage p0: edge detection and measurement on the incoming sample ----
  assign rise_p0 = de & ~de_d;
  assign fall_p0 = ~de & de_d;

  // A long enough low stretch before a rise can only be vertical blanking.
  assign frame_rise_p0 = rise_p0 & (gap_cnt >= H_PERIOD_C);
  assign line_rise_p0  = rise_p0 & ~frame_rise_p0;

  sat_run_counter u_gap (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (rise_p0),
    .en      (~de),
    .cnt     (gap_cnt)
  );

  sat_run_counter u_run (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (rise_p0),
    .en      (de),
    .cnt     (run_cnt)
  );

  sat_run_counter u_per (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (rise_p0),
    .en      (1'b1),
    .cnt     (per_cnt)
  );

  // Geometry checks are meaningless before the first frame boundary, and the
  // height check on that boundary has no measured frame behind it.
  assign ew_p0 = fall_p0 & (state_q != SEARCH) & (run_cnt != H_ACTIVE_C);
  assign ep_p0 = line_rise_p0 & (state_q != SEARCH) & (per_cnt != H_PERIOD_C);
  assign eh_p0 = frame_rise_p0 & (state_q != SEARCH) & (pixel_y != V_LAST_C);
  assign frame_clean_p0 = ~dirty_q & ~eh_p0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      clean_q <= '0;
      dirty_q <= 1'b0;
      de_d    <= 1'b1;
    end else begin
      state_q <= state_nx;
      clean_q <= clean_nx;
      dirty_q <= dirty_nx;
      de_d    <= de;
    end
  end

  always_comb begin
    state_nx = state_q;
    clean_nx = clean_q;
    dirty_nx = dirty_q | ew_p0 | ep_p0;
    if (frame_rise_p0) begin
      dirty_nx = 1'b0;
      unique case (state_q)
        SEARCH: begin
          state_nx = SYNC;
          clean_nx = '0;
        end
        SYNC: begin
          if (!frame_clean_p0) begin
            clean_nx = '0;
          end else if ((clean_q + 4'd1) == LOCK_C) begin
            state_nx = LOCKED;
          end else begin
            clean_nx = clean_q + 4'd1;
          end
        end
        LOCKED: begin
          if (eh_p0) begin
            state_nx = SYNC;
            clean_nx = '0;
          end
        end
        default: begin
          state_nx = SEARCH;
          clean_nx = '0;
        end
      endcase
    end else if ((ew_p0 | ep_p0) && state_q == LOCKED) begin
      state_nx = SYNC;
      clean_nx = '0;
    end
  end

  // Gating follows the post-update state so the first frame boundary's
  // strobes are already visible.
  always_comb begin
    active_p0 = (state_nx != SEARCH);
    valid_nx  = de & active_p0;
    ls_nx     = rise_p0 & active_p0;
    fs_nx     = frame_rise_p0 & active_p0;
    x_nx      = pixel_x;
    y_nx      = pixel_y;
    if (rise_p0) begin
      x_nx = '0;
    end else if (de) begin
      x_nx = sat_inc(pixel_x);
    end
    if (frame_rise_p0) begin
      y_nx = '0;
    end else if (line_rise_p0) begin
      y_nx = sat_inc(pixel_y);
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_width   <= 1'b0;
      err_period  <= 1'b0;
      err_height  <= 1'b0;
    end else begin
      pixel_valid <= valid_nx;
      pixel_x     <= x_nx;
      pixel_y     <= y_nx;
      line_start  <= ls_nx;
      frame_start <= fs_nx;
      locked      <= (state_q == LOCKED);
      err_width   <= ew_p0;
      err_period  <= ep_p0;
      err_height  <= eh_p0;
    end
  end

endmodule

// File: doc/lcd_de_timing_decoder.md
Name: lcd_de_timing_decoder

Overview:
Sink-side decoder for the DE-mode LCD scan stream. It watches `de` one pixel per clock and recovers the pixel coordinates, line and frame start strobes, and a lock indication. It also checks the measured geometry against the configured timing. It sits beside the panel model in simulation and on a loopback path in hardware, so that generator output can be self-checked.

Parameters:
H_ACTIVE, 800, active pixels per line
H_PERIOD, 928, pixel clocks per line, including blanking
V_ACTIVE, 480, active lines per frame
V_PERIOD, 525, lines per frame, including blanking
LOCK_FRAMES, 2, consecutive clean frames required to assert locked (1..15)

Ports:
clock  input  1  pixel clock; one pixel per cycle
reset_n  input  1  synchronous, active-low reset
de  input  1  data enable from the scan generator
pixel_valid  output  1  registered copy of de, gated by state != SEARCH
pixel_x  output  16  column of the pixel flagged by pixel_valid
pixel_y  output  16  line index within the frame
line_start  output  1  one-cycle pulse coincident with pixel_x == 0
frame_start  output  1  one-cycle pulse coincident with x == 0, y == 0
locked  output  1  high while state == LOCKED
err_width  output  1  one-cycle pulse: active run length != H_ACTIVE
err_period  output  1  one-cycle pulse: line rising-to-rising distance != H_PERIOD
err_height  output  1  one-cycle pulse: completed frame line count != V_ACTIVE

Behaviour:
- One clock (`clock`); reset is synchronous and active-low (`reset_n`).
- Reset values: all outputs 0; de_d = 1, so a line already in progress at reset release is ignored; counters 0; state SEARCH.
- Edges: rise = de & ~de_d; fall = ~de & de_d.
- gap_cnt counts consecutive de == 0 cycles, saturates at 16'hFFFF, and clears on rise.
- run_cnt counts de == 1 cycles, saturating.
- per_cnt counts cycles since the last rise, saturating.
- Frame boundary: a rise with gap_cnt >= H_PERIOD.
- Line boundary: any other rise.
- Output latency is 1 cycle. The outputs for the input sample on cycle n appear on cycle n+1.
- On a frame boundary rise: pixel_x = 0, pixel_y = 0, frame_start = 1, line_start = 1.
- On a line boundary rise: pixel_x = 0, pixel_y increments (saturating), line_start = 1.
- While de stays high: pixel_x increments, saturating at 16'hFFFF. It may exceed H_ACTIVE-1 and is flagged later.
- While de is low: pixel_x and pixel_y hold.
- In SEARCH: strobes, pixel_valid and errors are forced to 0. Counters still run.
- State machine:
  - SEARCH -> SYNC on the first frame boundary; clean_cnt = 0.
  - SYNC -> LOCKED on a frame boundary where the frame just ended was clean and clean_cnt + 1 == LOCK_FRAMES. Otherwise clean_cnt increments on a clean frame and clears on a dirty one.
  - LOCKED -> SYNC on any error pulse; clean_cnt = 0; locked drops on the following cycle.
- A frame is clean when no error pulse occurred between two consecutive frame boundaries and its line count == V_ACTIVE.
- err_width: pulses on the cycle after a fall if run_cnt != H_ACTIVE. Evaluated in SYNC and LOCKED only.
- err_period: pulses with line_start on line-boundary rises (not frame boundaries) if per_cnt != H_PERIOD.
- err_height: pulses with frame_start if the previous frame's line count != V_ACTIVE. It is suppressed on the SEARCH -> SYNC boundary, because no prior frame was measured.
- Simultaneous events: a frame boundary in which both err_height and a stale error apply is classified dirty once. The transition to SYNC takes precedence over lock promotion.
- de stuck low: gap_cnt saturates, outputs hold, and state is unchanged. The next rise is a frame boundary.
- de stuck high: run_cnt and pixel_x saturate. On the eventual fall, err_width fires.
- Reset mid-frame: immediate return to reset values on the next edge. The half line is ignored via de_d = 1.

Decomposition:
- Package lcd_timing_pkg contains:
  - state enum {SEARCH, SYNC, LOCKED};
  - default timing constants shared with the scan generator;
  - coordinate typedef `logic [15:0]`.
- One natural sub-module, sat_run_counter. It provides a 16-bit saturating counter with clear and enable, instantiated for gap, run and period measurement.

Test Plan:
All scenarios use bench parameters H_ACTIVE = 8, H_PERIOD = 12, V_ACTIVE = 4, V_PERIOD = 6, LOCK_FRAMES = 2. The frame gap is therefore 28 low cycles.
1. Ideal stream for 4 frames: locked rises 1 cycle after the 3rd frame_start. Every line shows pixel_x 0..7; pixel_y runs 0..3; no error pulses.
2. Line 2 of frame 3 has 9 high cycles: err_width pulses 1 cycle after its fall; locked drops; relock occurs after 2 further clean frames.
3. One line gap shortened to 3 low cycles (period 11): err_period pulses together with that line's line_start.
4. A frame with 3 active lines: err_height pulses with the next frame_start, and that frame is counted dirty.
5. Reset asserted mid-line while de = 1, then released: no line_start until de falls and rises again. State is SEARCH and all outputs are 0.
6. de held low for 70000 cycles: no pulses, pixel coordinates hold; the next rise produces frame_start with pixel_x = 0, pixel_y = 0.
